p2s_serializer: RTL

- Parametrised parallel-to-serial converter with a ready/valid input handshake and a qualified serial output.
- Takes a WIDTH-bit word and shifts it out one bit per CLK with valid_out asserted for each data bit.
- Sits between the parallel word source and the serial link stage, replacing the single-bit conditional flop stage with a full word serializer.
- Adds configurable bit order, back-to-back word streaming, an idle line level and a frame marker.

---
 rtl/p2s_pkg.sv | 26 ++
 rtl/p2s_bit_counter.sv | 50 +++++
 rtl/p2s_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/p2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : p2s_pkg
// Brief    : Shared constants and helpers for the parallel/serial link blocks
//            (state encoding, counter-width helper, default idle line level).
// Revision : 1.0 - initial release
// ============================================================================
package p2s_pkg;

  // Serializer state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Default level of the serial line between words
  localparam logic P2S_IDLE_VAL = 1'b0;

  // Bits needed to count 0..w-1; never less than one bit
  function automatic int cnt_width(input int w);
    int r;
    for (r = 0; (1 << r) < w; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p2s_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : p2s_bit_counter
// Brief    : Mod-WIDTH bit counter with clear, load and enable, plus a flag
//            that marks the last bit position of a word.
// Revision : 1.0 - initial release
// ============================================================================
module p2s_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          last_o
);

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear beats load beats increment; wraps after the last bit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/p2s_serializer.sv
`default_nettype none
// ============================================================================
// Module   : p2s_serializer
// Brief    : Parallel-to-serial converter with ready/valid word input,
//            selectable bit order, optional gapless streaming, idle line
//            level and a first-bit frame marker.
// Revision : 1.0 - initial release
// ============================================================================
module p2s_serializer
  import p2s_pkg::*;
#(
  parameter int   WIDTH        = 8,
  parameter bit   MSB_FIRST    = 1'b1,
  parameter logic IDLE_VAL     = P2S_IDLE_VAL,
  parameter bit   BACK_TO_BACK = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             serial_out,
  output logic             valid_out,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_q, ser_d;
  logic             vld_q, vld_d;
  logic             frm_q, frm_d;

  logic             last_w;
  logic             accept_w;
  logic             in_shift_w;
  logic             first_bit_w;
  logic [WIDTH-1:0] data_adv_w;
  logic             next_bit_w;
  logic [WIDTH-1:0] shreg_adv_w;

  assign in_shift_w = (state_q == ST_SHIFT);

  // Ready from registered state only; a new word may overlap the last bit
  // when streaming is enabled
  assign ready_out = ENB & ~RESET &
                     ((state_q == ST_IDLE) | (BACK_TO_BACK & in_shift_w & last_w));
  assign accept_w  = valid_in & ready_out;

  // The first bit leaves directly from data_in; the register keeps the rest
  assign first_bit_w = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign data_adv_w  = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
  assign next_bit_w  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_adv_w = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  p2s_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .clr_i      (~ENB | (in_shift_w & last_w & ~accept_w)),
    .load_i     (accept_w),
    .load_val_i ('0),
    .en_i       (in_shift_w),
    .last_o     (last_w)
  );

  // Next state and output values: flush, load a new word, shift, or go idle
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    ser_d   = IDLE_VAL;
    vld_d   = 1'b0;
    frm_d   = 1'b0;
    if (!ENB) begin
      state_d = ST_IDLE;
      shreg_d = '0;
    end else if (accept_w) begin
      state_d = ST_SHIFT;
      shreg_d = data_adv_w;
      ser_d   = first_bit_w;
      vld_d   = 1'b1;
      frm_d   = 1'b1;
    end else if (in_shift_w && !last_w) begin
      shreg_d = shreg_adv_w;
      ser_d   = next_bit_w;
      vld_d   = 1'b1;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // State, shift register and registered serial outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      ser_q   <= IDLE_VAL;
      vld_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      ser_q   <= ser_d;
      vld_q   <= vld_d;
      frm_q   <= frm_d;
    end
  end

  assign serial_out  = ser_q;
  assign valid_out   = vld_q;
  assign frame_start = frm_q;
  assign busy        = in_shift_w;

endmodule
`default_nettype wire
